// File: rtl/core_lsu_axil.sv
// Load/store unit: RV32I memory-stage request/response port to an AXI4-Lite master.
// One transaction in flight. Lane steering, strobes and load extension come from the
// captured address; misaligned requests and bus errors are reported, and every AXI
// wait phase is bounded by an optional timeout.
module core_lsu_axil #(
    parameter int unsigned AXI_AWIDTH     = 32,
    parameter int unsigned AXI_DWIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    // pipeline request
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [31:0]             i_req_addr,
    input  logic [31:0]             i_req_wdata,
    // pipeline response
    output logic                    o_rsp_valid,
    output logic [31:0]             o_rsp_rdata,
    output logic [1:0]              o_rsp_err,
    output logic                    o_busy,
    // AXI4-Lite write address
    output logic                    o_axi_awvalid,
    input  logic                    i_axi_awready,
    output logic [AXI_AWIDTH-1:0]   o_axi_awaddr,
    output logic [2:0]              o_axi_awprot,
    // AXI4-Lite write data
    output logic                    o_axi_wvalid,
    input  logic                    i_axi_wready,
    output logic [AXI_DWIDTH-1:0]   o_axi_wdata,
    output logic [AXI_DWIDTH/8-1:0] o_axi_wstrb,
    // AXI4-Lite write response
    input  logic                    i_axi_bvalid,
    output logic                    o_axi_bready,
    input  logic [1:0]              i_axi_bresp,
    // AXI4-Lite read address
    output logic                    o_axi_arvalid,
    input  logic                    i_axi_arready,
    output logic [AXI_AWIDTH-1:0]   o_axi_araddr,
    output logic [2:0]              o_axi_arprot,
    // AXI4-Lite read data
    input  logic                    i_axi_rvalid,
    output logic                    o_axi_rready,
    input  logic [AXI_DWIDTH-1:0]   i_axi_rdata,
    input  logic [1:0]              i_axi_rresp
);

    localparam int unsigned SW       = AXI_DWIDTH / 8;
    localparam int unsigned OFFW     = $clog2(SW);
    localparam int unsigned REPL     = AXI_DWIDTH / 32;
    localparam int unsigned TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_MIS  = 2'b01;
    localparam logic [1:0] ERR_BUS  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_req_ready, w_req_ready_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [1:0]          r_rsp_err, w_rsp_err_nxt;
    logic [31:0]         r_rsp_rdata, w_rsp_rdata_nxt;
    logic                r_awvalid, w_awvalid_nxt;
    logic                r_wvalid, w_wvalid_nxt;
    logic                r_bready, w_bready_nxt;
    logic                r_arvalid, w_arvalid_nxt;
    logic                r_rready, w_rready_nxt;
    logic [TW-1:0]       r_tmo, w_tmo_nxt;

    logic [AXI_AWIDTH-1:0] r_addr;
    logic [OFFW-1:0]       r_off;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [AXI_DWIDTH-1:0] r_wdata_bus;
    logic [SW-1:0]         r_wstrb;

    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_tmo_hit;
    logic [OFFW-1:0]       w_req_off;
    logic [AXI_DWIDTH-1:0] w_wdata_bus;
    logic [SW-1:0]         w_strb_base;
    logic [SW-1:0]         w_wstrb;
    logic [31:0]           w_rlane;
    logic [31:0]           w_load_ext;
    logic                  w_aw_done;
    logic                  w_w_done;
    logic                  w_unused;

    // Request decode: accept, alignment and write-lane steering from the incoming address
    assign w_accept     = (r_state == S_IDLE) && r_req_ready && i_req_valid;
    assign w_req_off    = i_req_addr[OFFW-1:0];
    assign w_misaligned = (i_req_size == 2'b11)
                       || ((i_req_size == 2'b01) && i_req_addr[0])
                       || ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
    assign w_wdata_bus  = {REPL{i_req_wdata}} << {w_req_off, 3'b000};
    assign w_wstrb      = w_strb_base << w_req_off;
    assign w_tmo_hit    = (TIMEOUT_CYCLES != 0) && (r_tmo == TW'(TMO_LAST));
    assign w_unused     = ^{i_axi_bresp[0], i_axi_rresp[0]};

    // Byte-enable pattern for the access size before lane shifting
    always_comb begin
        w_strb_base = '0;
        case (i_req_size)
            2'b00:   w_strb_base = SW'(4'h1);
            2'b01:   w_strb_base = SW'(4'h3);
            2'b10:   w_strb_base = SW'(4'hF);
            default: w_strb_base = '0;
        endcase
    end

    // Load lane extraction and sign/zero extension from the captured size/offset
    assign w_rlane = 32'(i_axi_rdata >> {r_off, 3'b000});
    always_comb begin
        w_load_ext = w_rlane;
        case (r_size)
            2'b00:   w_load_ext = r_unsigned ? {24'd0, w_rlane[7:0]}
                                             : {{24{w_rlane[7]}}, w_rlane[7:0]};
            2'b01:   w_load_ext = r_unsigned ? {16'd0, w_rlane[15:0]}
                                             : {{16{w_rlane[15]}}, w_rlane[15:0]};
            default: w_load_ext = w_rlane;
        endcase
    end

    // Capture request fields and steered write payload at accept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_off       <= '0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_wdata_bus <= '0;
            r_wstrb     <= '0;
        end else if (w_accept) begin
            r_addr      <= i_req_addr[AXI_AWIDTH-1:0];
            r_off       <= w_req_off;
            r_size      <= i_req_size;
            r_unsigned  <= i_req_unsigned;
            r_wdata_bus <= w_wdata_bus;
            r_wstrb     <= w_wstrb;
        end
    end

    // Next-state and next-output logic; every handshake output is registered
    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_tmo_nxt       = r_tmo + TW'(1);
        w_aw_done       = !r_awvalid || i_axi_awready;
        w_w_done        = !r_wvalid || i_axi_wready;

        case (r_state)
            S_IDLE: begin
                w_tmo_nxt = '0;
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = ERR_MIS;
                        w_rsp_rdata_nxt = '0;
                    end else if (i_req_we) begin
                        w_state_nxt   = S_WRITE;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_RADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_awvalid_nxt = r_awvalid && !i_axi_awready;
                w_wvalid_nxt  = r_wvalid && !i_axi_wready;
                if (w_aw_done && w_w_done) begin
                    w_state_nxt  = S_WRESP;
                    w_bready_nxt = 1'b1;
                    w_tmo_nxt    = '0;
                end else if (w_tmo_hit) begin
                    w_state_nxt     = S_RESP;
                    w_awvalid_nxt   = 1'b0;
                    w_wvalid_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = ERR_TMO;
                    w_rsp_rdata_nxt = '0;
                end
            end
            S_WRESP: begin
                if (i_axi_bvalid) begin
                    w_state_nxt     = S_RESP;
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = i_axi_bresp[1] ? ERR_BUS : ERR_OK;
                    w_rsp_rdata_nxt = '0;
                end else if (w_tmo_hit) begin
                    w_state_nxt     = S_RESP;
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = ERR_TMO;
                    w_rsp_rdata_nxt = '0;
                end
            end
            S_RADDR: begin
                if (i_axi_arready) begin
                    w_state_nxt   = S_RDATA;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_tmo_nxt     = '0;
                end else if (w_tmo_hit) begin
                    w_state_nxt     = S_RESP;
                    w_arvalid_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = ERR_TMO;
                    w_rsp_rdata_nxt = '0;
                end
            end
            S_RDATA: begin
                if (i_axi_rvalid) begin
                    w_state_nxt     = S_RESP;
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = i_axi_rresp[1] ? ERR_BUS : ERR_OK;
                    w_rsp_rdata_nxt = i_axi_rresp[1] ? 32'd0 : w_load_ext;
                end else if (w_tmo_hit) begin
                    w_state_nxt     = S_RESP;
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = ERR_TMO;
                    w_rsp_rdata_nxt = '0;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_tmo_nxt   = '0;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
                w_tmo_nxt     = '0;
            end
        endcase

        w_req_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= '0;
            r_rsp_rdata <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_tmo       <= w_tmo_nxt;
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_busy        = r_busy;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_axi_awvalid = r_awvalid;
    assign o_axi_awaddr  = r_addr;
    assign o_axi_awprot  = 3'b000;
    assign o_axi_wvalid  = r_wvalid;
    assign o_axi_wdata   = r_wdata_bus;
    assign o_axi_wstrb   = r_wstrb;
    assign o_axi_bready  = r_bready;
    assign o_axi_arvalid = r_arvalid;
    assign o_axi_araddr  = r_addr;
    assign o_axi_arprot  = 3'b000;
    assign o_axi_rready  = r_rready;

endmodule

// File: tb/tb_core_lsu_axil.sv
// Self-checking bench for core_lsu_axil: directed scenarios followed by randomized
// transactions against an AXI4-Lite slave model with programmable ready delays and
// responses; expectations come from a byte-level reference model.
module tb_core_lsu_axil;

    localparam int unsigned TMO = 8;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;

    // slave configuration and observation
    int          aw_dly, w_dly, ar_dly;
    logic        ar_never;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    int          aw_cnt, w_cnt, ar_cnt;
    int          n_aw, n_w, n_ar;
    logic        aw_seen, w_seen;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    core_lsu_axil #(
        .AXI_AWIDTH(32), .AXI_DWIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy),
        .o_axi_awvalid(awvalid), .i_axi_awready(awready), .o_axi_awaddr(awaddr), .o_axi_awprot(awprot),
        .o_axi_wvalid(wvalid), .i_axi_wready(wready), .o_axi_wdata(wdata), .o_axi_wstrb(wstrb),
        .i_axi_bvalid(bvalid), .o_axi_bready(bready), .i_axi_bresp(bresp),
        .o_axi_arvalid(arvalid), .i_axi_arready(arready), .o_axi_araddr(araddr), .o_axi_arprot(arprot),
        .i_axi_rvalid(rvalid), .o_axi_rready(rready), .i_axi_rdata(rdata), .i_axi_rresp(rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave ready: each channel accepts once its VALID has waited the programmed number of cycles
    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign arready = arvalid && !ar_never && (ar_cnt >= ar_dly);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
        end
    end

    // Slave responses: B after both write handshakes, R after the AR handshake
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_seen <= 1'b0; w_seen <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'd0;
            n_aw <= 0; n_w <= 0; n_ar <= 0;
            cap_awaddr <= 32'd0; cap_wdata <= 32'd0; cap_wstrb <= 4'd0; cap_araddr <= 32'd0;
        end else begin
            if (awvalid && awready) begin
                aw_seen <= 1'b1; cap_awaddr <= awaddr; n_aw <= n_aw + 1;
            end
            if (wvalid && wready) begin
                w_seen <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb; n_w <= n_w + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
            end else if (!bvalid && (aw_seen || (awvalid && awready))
                                 && (w_seen || (wvalid && wready))) begin
                bvalid <= 1'b1; bresp <= cfg_bresp;
            end
            if (arvalid && arready) begin
                cap_araddr <= araddr; n_ar <= n_ar + 1;
                rvalid <= 1'b1; rdata <= cfg_rdata; rresp <= cfg_rresp;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-level view of what the bus and the response should carry
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] bus_rd,
                         input logic [1:0] br, input logic [1:0] rr,
                         output logic [1:0] e_err, output logic [31:0] e_rdata,
                         output logic [31:0] e_wdata, output logic [3:0] e_strb, output logic e_axi);
        int     off;
        int     nb;
        longint v;
        longint full;
        off     = int'(addr % 4);
        nb      = 1 << size;
        e_wdata = 32'd0;
        e_strb  = 4'd0;
        e_rdata = 32'd0;
        e_axi   = 1'b0;
        if (size == 2'd3 || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && off != 0)) begin
            e_err = 2'b01;
        end else begin
            e_axi = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (i >= off) e_wdata[8*i +: 8] = wd[8*(i-off) +: 8];
                if (i >= off && i < off + nb) e_strb[i] = 1'b1;
            end
            if (we) begin
                e_err = br[1] ? 2'b10 : 2'b00;
            end else begin
                e_err = rr[1] ? 2'b10 : 2'b00;
                full  = longint'(1) << (8 * nb);
                v     = (longint'(bus_rd) >> (8 * off)) % full;
                if (!uns && nb < 4 && v >= full / 2) v = v - full;
                if (!rr[1]) e_rdata = 32'(v);
            end
        end
    endtask

    // One request through the pipeline port; latency counted in cycles after the accept edge
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [1:0] err, output logic [31:0] rd,
                           output logic saw_axi, output int ar_cyc);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; saw_axi = 1'b0; ar_cyc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (awvalid || wvalid || arvalid) saw_axi = 1'b1;
            if (arvalid) ar_cyc++;
        end while (!rsp_valid && lat < 60);
        check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        err = rsp_err;
        rd  = rsp_rdata;
        check("resp_cycle_ready_busy", 32'({req_ready, busy}), 32'b01);
        @(negedge clk);
        check("after_resp_valid_ready_busy", 32'({rsp_valid, req_ready, busy}), 32'b010);
    endtask

    initial begin
        int          lat, ar_cyc, b_aw, b_w, b_ar;
        logic [1:0]  err, e_err;
        logic [31:0] rd, e_rdata, e_wdata;
        logic [3:0]  e_strb;
        logic        saw, e_axi;
        logic        r_we, r_uns;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wd;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; ar_never = 1'b0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'd0;

        // reset state
        #12;
        check("reset_handshake_outputs",
              32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, req_ready, busy}), 32'd0);
        check("reset_rsp_rdata_err", rsp_rdata | 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // store byte at 0x1003, zero-wait slave
        run_txn(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, lat, err, rd, saw, ar_cyc);
        check("sb_latency", 32'(lat), 32'd3);
        check("sb_err", 32'(err), 32'd0);
        check("sb_awaddr", cap_awaddr, 32'h0000_1003);
        check("sb_wstrb", 32'(cap_wstrb), 32'h8);
        check("sb_wdata", cap_wdata, 32'hAB00_0000);

        // load byte signed / unsigned at 0x2002
        cfg_rdata = 32'h00F0_0000;
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_2002, 32'd0, lat, err, rd, saw, ar_cyc);
        check("lb_latency", 32'(lat), 32'd3);
        check("lb_araddr", cap_araddr, 32'h0000_2002);
        check("lb_rdata", rd, 32'hFFFF_FFF0);
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_2002, 32'd0, lat, err, rd, saw, ar_cyc);
        check("lbu_rdata", rd, 32'h0000_00F0);
        check("lbu_err", 32'(err), 32'd0);

        // misaligned word load and half store
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0, lat, err, rd, saw, ar_cyc);
        check("mis_w_err", 32'(err), 32'd1);
        check("mis_w_latency", 32'(lat), 32'd1);
        check("mis_w_no_axi", 32'(saw), 32'd0);
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_3003, 32'h1234, lat, err, rd, saw, ar_cyc);
        check("mis_h_err", 32'(err), 32'd1);
        check("mis_h_no_axi", 32'(saw), 32'd0);

        // AW accepted three cycles ahead of W, then SLVERR
        aw_dly = 0; w_dly = 3; cfg_bresp = 2'b10;
        b_aw = n_aw; b_w = n_w;
        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h1234_5678, lat, err, rd, saw, ar_cyc);
        check("dly_aw_count", 32'(n_aw - b_aw), 32'd1);
        check("dly_w_count", 32'(n_w - b_w), 32'd1);
        check("dly_err", 32'(err), 32'd2);
        check("dly_wdata", cap_wdata, 32'h1234_5678);
        check("dly_wstrb", 32'(cap_wstrb), 32'hF);
        w_dly = 0; cfg_bresp = 2'b00;

        // read address never accepted
        ar_never = 1'b1;
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'd0, lat, err, rd, saw, ar_cyc);
        check("tmo_err", 32'(err), 32'd3);
        check("tmo_arvalid_cycles", 32'(ar_cyc), 32'(TMO));
        check("tmo_latency", 32'(lat), 32'(TMO + 1));
        check("tmo_rdata", rd, 32'd0);
        ar_never = 1'b0;

        // asynchronous reset while AWVALID is pending
        aw_dly = 5; w_dly = 5;
        @(negedge clk);
        begin : wait_ready
            int g;
            g = 0;
            while (!req_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
        end
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_6000; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("midrst_awvalid_before", 32'({awvalid, busy}), 32'b11);
        #1 rst = 1'b1;
        #1;
        check("midrst_outputs_cleared",
              32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, req_ready, busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        aw_dly = 0; w_dly = 0;
        b_aw = n_aw;
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_6002, 32'h0000_BEEF, lat, err, rd, saw, ar_cyc);
        check("post_rst_err", 32'(err), 32'd0);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_aw_count", 32'(n_aw - b_aw), 32'd1);
        check("post_rst_wdata", cap_wdata, 32'hBEEF_0000);
        check("post_rst_wstrb", 32'(cap_wstrb), 32'hC);

        // randomized transactions against the reference model
        for (int t = 0; t < 60; t++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_uns  = 1'($urandom_range(0, 1));
            r_addr = $urandom;
            r_wd   = $urandom;
            aw_dly = int'($urandom_range(0, 3));
            w_dly  = int'($urandom_range(0, 3));
            ar_dly = int'($urandom_range(0, 3));
            cfg_bresp = 2'($urandom_range(0, 3));
            cfg_rresp = 2'($urandom_range(0, 3));
            cfg_rdata = $urandom;
            b_aw = n_aw; b_w = n_w; b_ar = n_ar;
            run_txn(r_we, r_size, r_uns, r_addr, r_wd, lat, err, rd, saw, ar_cyc);
            model(r_we, r_size, r_uns, r_addr, r_wd, cfg_rdata, cfg_bresp, cfg_rresp,
                  e_err, e_rdata, e_wdata, e_strb, e_axi);
            check("rnd_err", 32'(err), 32'(e_err));
            check("rnd_rdata", rd, e_rdata);
            if (!e_axi) begin
                check("rnd_no_axi", 32'(saw), 32'd0);
            end else if (r_we) begin
                check("rnd_aw_count", 32'(n_aw - b_aw), 32'd1);
                check("rnd_w_count", 32'(n_w - b_w), 32'd1);
                check("rnd_awaddr", cap_awaddr, r_addr);
                check("rnd_wdata", cap_wdata, e_wdata);
                check("rnd_wstrb", 32'(cap_wstrb), 32'(e_strb));
            end else begin
                check("rnd_ar_count", 32'(n_ar - b_ar), 32'd1);
                check("rnd_araddr", cap_araddr, r_addr);
            end
        end

        check("prot_tied_low", 32'({awprot, arprot}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
